// File: rtl/memory_responder_pkg.sv
// Shared types for the main-memory responder: physical line address, cache line payload and
// the request record that travels through the responder's queue.
package memory_responder_pkg;

  localparam int PADDR_W     = 32;
  localparam int LINE_BYTES  = 16;
  localparam int LINE_W      = LINE_BYTES * 8;
  localparam int OFFSET_W    = $clog2(LINE_BYTES);
  localparam int MEM_LATENCY = 5;

  typedef logic [PADDR_W-1:0] pptr_t;
  typedef logic [LINE_W-1:0]  cacheline_t;

  typedef enum logic {
    MEMSRC_I = 1'b0,
    MEMSRC_D = 1'b1
  } memsrc_t;

  typedef struct packed {
    memsrc_t    src;
    logic       we;
    pptr_t      addr;
    cacheline_t line;
  } memreq_t;

  // Clears the byte-within-line offset so queued and returned addresses are line-aligned.
  function automatic pptr_t line_align(input pptr_t a);
    return a & ~pptr_t'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/memory_responder_fifo.sv
// In-order request queue for the memory responder. Full/empty come from the registered count,
// so a pop in the same cycle does not make room for a push.
module memreq_fifo
  import memory_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  memreq_t req_i,
  input  logic    pop_i,
  output memreq_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  memreq_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= req_i;
  end

endmodule

// File: rtl/memory_responder.sv
// Far end of the I/D cache refill interface: arbitrates I and D requests into an in-order queue,
// services each after a fixed latency against the backing store and returns lines on the rec bus.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int LATENCY   = MEM_LATENCY,
  parameter int QDEPTH    = 4,
  parameter int MEM_LINES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_ren,
  input  pptr_t      i_req_addr,
  output logic       i_req_ready,
  input  logic       d_req_ren,
  input  logic       d_req_wen,
  input  pptr_t      d_req_addr,
  input  cacheline_t d_req_cacheline,
  output logic       d_req_ready,
  output logic       i_rec_en,
  output logic       d_rec_en,
  output logic       d_wack,
  output pptr_t      rec_addr,
  output cacheline_t rec_cacheline
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  logic       i_pend, d_pend;
  logic       grant_i, grant_d;
  logic       q_full, q_empty, q_pop;
  memreq_t    push_req, q_head;
  memsrc_t    rr_q;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  memreq_t          svc_q;
  logic             i_rec_en_q, d_rec_en_q, d_wack_q;
  pptr_t            rec_addr_q;
  cacheline_t       rec_line_q;

  cacheline_t       store_q [MEM_LINES];
  logic [IDX_W-1:0] svc_idx;
  logic             store_we;

  // Round-robin only matters when both sides want in; a lone requester always wins.
  assign i_pend      = i_req_ren;
  assign d_pend      = d_req_ren | d_req_wen;
  assign i_req_ready = !q_full && (!d_pend || rr_q == MEMSRC_I);
  assign d_req_ready = !q_full && (!i_pend || rr_q == MEMSRC_D);
  assign grant_i     = i_pend && i_req_ready;
  assign grant_d     = d_pend && d_req_ready;

  always_comb begin
    push_req = '0;
    if (grant_i) begin
      push_req.src  = MEMSRC_I;
      push_req.we   = 1'b0;
      push_req.addr = line_align(i_req_addr);
    end else if (grant_d) begin
      push_req.src  = MEMSRC_D;
      push_req.we   = d_req_wen;
      push_req.addr = line_align(d_req_addr);
      push_req.line = d_req_wen ? d_req_cacheline : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= MEMSRC_I;
    end else if (grant_i) begin
      rr_q <= MEMSRC_D;
    end else if (grant_d) begin
      rr_q <= MEMSRC_I;
    end
  end

  memreq_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (grant_i | grant_d),
    .req_i   (push_req),
    .pop_i   (q_pop),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign q_pop    = (state_q == ST_IDLE) && !q_empty;
  assign svc_idx  = svc_q.addr[OFFSET_W +: IDX_W];
  assign store_we = (state_q == ST_BUSY) && (cnt_q == '0) && svc_q.we;

  always_ff @(posedge clk) begin
    if (store_we) store_q[svc_idx] <= svc_q.line;
  end

  // Pulse outputs default low every cycle; they are raised only on the closing BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      svc_q      <= '0;
      i_rec_en_q <= 1'b0;
      d_rec_en_q <= 1'b0;
      d_wack_q   <= 1'b0;
      rec_addr_q <= '0;
      rec_line_q <= '0;
    end else begin
      i_rec_en_q <= 1'b0;
      d_rec_en_q <= 1'b0;
      d_wack_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!q_empty) begin
            svc_q   <= q_head;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (svc_q.we) begin
            d_wack_q <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            rec_addr_q <= svc_q.addr;
            rec_line_q <= store_q[svc_idx];
            i_rec_en_q <= (svc_q.src == MEMSRC_I);
            d_rec_en_q <= (svc_q.src == MEMSRC_D);
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign i_rec_en      = i_rec_en_q;
  assign d_rec_en      = d_rec_en_q;
  assign d_wack        = d_wack_q;
  assign rec_addr      = rec_addr_q;
  assign rec_cacheline = rec_line_q;

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder against a transaction-level model of the arbiter,
// queue occupancy, service timing and backing store.
module tb_memory_responder;
  import memory_responder_pkg::*;

  localparam int LAT = 5;
  localparam int QD  = 4;
  localparam int ML  = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_req_ren = 1'b0;
  pptr_t      i_req_addr = '0;
  logic       i_req_ready;
  logic       d_req_ren = 1'b0;
  logic       d_req_wen = 1'b0;
  pptr_t      d_req_addr = '0;
  cacheline_t d_req_cacheline = '0;
  logic       d_req_ready;
  logic       i_rec_en, d_rec_en, d_wack;
  pptr_t      rec_addr;
  cacheline_t rec_cacheline;

  always #5 clk = ~clk;

  memory_responder #(
    .LATENCY   (LAT),
    .QDEPTH    (QD),
    .MEM_LINES (ML)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_ren       (i_req_ren),
    .i_req_addr      (i_req_addr),
    .i_req_ready     (i_req_ready),
    .d_req_ren       (d_req_ren),
    .d_req_wen       (d_req_wen),
    .d_req_addr      (d_req_addr),
    .d_req_cacheline (d_req_cacheline),
    .d_req_ready     (d_req_ready),
    .i_rec_en        (i_rec_en),
    .d_rec_en        (d_rec_en),
    .d_wack          (d_wack),
    .rec_addr        (rec_addr),
    .rec_cacheline   (rec_cacheline)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          is_i;
    bit          we;
    logic [31:0] addr;
    logic [127:0] line;
    int          cyc;
  } resp_t;

  resp_t        exp_q[$];
  int           pop_q[$];
  logic [127:0] m_mem [int];
  bit           m_rr_d = 1'b0;
  int           m_free = 0;
  int           cyc = 0;
  logic [31:0]  m_last_addr = '0;
  logic [127:0] m_last_line = '0;
  int           last_acc = -1;
  int           last_i_cyc = -1;
  int           last_wack_cyc = -1;

  bit           i_act = 1'b0;
  logic [31:0]  i_a = '0;
  bit           d_act = 1'b0;
  bit           d_w = 1'b0;
  logic [31:0]  d_a = '0;
  logic [127:0] d_l = '0;

  logic [31:0] pool [8] = '{32'h0000_0040, 32'h0000_0100, 32'h0000_1040, 32'h0000_2230,
                            32'h0001_0040, 32'h0000_ffe0, 32'h0003_4560, 32'h0000_0800};

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: requests are serviced strictly in order; a read's data is whatever the store holds
  // once all earlier queued requests have taken effect.
  task automatic accept(input bit is_i, input bit we, input logic [31:0] addr, input logic [127:0] line);
    resp_t e;
    int    s;
    int    idx;
    s   = (cyc + 1 > m_free) ? cyc + 1 : m_free;
    idx = int'((addr >> 4) % ML);
    pop_q.push_back(s);
    e.is_i = is_i;
    e.we   = we;
    e.addr = addr & ~32'hF;
    e.cyc  = s + LAT + 1;
    if (we) begin
      m_mem[idx] = line;
      e.line     = line;
      m_free     = s + LAT + 1;
    end else begin
      e.line = m_mem[idx];
      m_free = s + LAT + 2;
    end
    exp_q.push_back(e);
    last_acc = cyc;
    $display("txn cyc=%0d src=%s we=%0d addr=%h due=%0d", cyc, is_i ? "I" : "D", we, addr, e.cyc);
  endtask

  task automatic step(input logic rst_val);
    resp_t e;
    bit    exp_i, exp_d, exp_w, full, gi, gd;
    @(negedge clk);
    exp_i = 1'b0;
    exp_d = 1'b0;
    exp_w = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      if (e.we) begin
        exp_w = 1'b1;
      end else begin
        exp_i       = e.is_i;
        exp_d       = !e.is_i;
        m_last_addr = e.addr;
        m_last_line = e.line;
      end
    end
    if (i_rec_en === 1'b1) last_i_cyc = cyc;
    if (d_wack === 1'b1) last_wack_cyc = cyc;
    check_eq("i_rec_en", i_rec_en, exp_i);
    check_eq("d_rec_en", d_rec_en, exp_d);
    check_eq("d_wack", d_wack, exp_w);
    check_eq("rec_addr", rec_addr, m_last_addr);
    check_eq("rec_cacheline", rec_cacheline, m_last_line);

    rst = rst_val;
    if (rst_val) begin
      exp_q.delete();
      pop_q.delete();
      m_rr_d      = 1'b0;
      m_free      = 0;
      m_last_addr = '0;
      m_last_line = '0;
      i_act       = 1'b0;
      d_act       = 1'b0;
    end
    i_req_ren       = i_act;
    i_req_addr      = i_a;
    d_req_ren       = d_act && !d_w;
    d_req_wen       = d_act && d_w;
    d_req_addr      = d_a;
    d_req_cacheline = d_l;
    #1;
    if (!rst_val) begin
      while (pop_q.size() > 0 && pop_q[0] < cyc) void'(pop_q.pop_front());
      full = (pop_q.size() >= QD);
      gi   = i_act && !full && (!d_act || !m_rr_d);
      gd   = d_act && !full && (!i_act || m_rr_d);
      if (i_act) check_eq("i_req_ready", i_req_ready, gi);
      if (d_act) check_eq("d_req_ready", d_req_ready, gd);
      if (gi) begin
        accept(1'b1, 1'b0, i_a, '0);
        m_rr_d = 1'b1;
        i_act  = 1'b0;
      end else if (gd) begin
        accept(1'b0, d_w, d_a, d_l);
        m_rr_d = 1'b0;
        d_act  = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic wait_idle_req();
    int n;
    n = 0;
    while ((i_act || d_act) && n < 60) begin
      step(1'b0);
      n++;
    end
    if (i_act || d_act) begin
      check_eq("accept_timeout", 1, 0);
      i_act = 1'b0;
      d_act = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      step(1'b0);
      n++;
    end
    check_eq("drain_timeout", exp_q.size(), 0);
    step(1'b0);
  endtask

  initial begin
    int t_w;

    repeat (3) step(1'b1);

    for (int k = 0; k < 8; k++) begin
      d_act = 1'b1; d_w = 1'b1; d_a = pool[k]; d_l = rand_line();
      wait_idle_req();
    end
    drain();

    // Single I read of a preloaded line: response exactly LATENCY+2 cycles after acceptance.
    i_act = 1'b1; i_a = 32'h0000_0040;
    wait_idle_req();
    drain();
    check_eq("i_read_latency", last_i_cyc - last_acc, LAT + 2);

    // Write then read of the same line through an unaligned address.
    d_act = 1'b1; d_w = 1'b1; d_a = 32'h0000_0100; d_l = rand_line();
    wait_idle_req();
    t_w = last_acc;
    d_act = 1'b1; d_w = 1'b0; d_a = 32'h0000_0104;
    wait_idle_req();
    drain();
    check_eq("d_wack_latency", last_wack_cyc - t_w, LAT + 2);

    // Both sources request every cycle: alternating grants, back-pressure once the queue fills.
    for (int c = 0; c < 8; c++) begin
      if (!i_act) begin i_act = 1'b1; i_a = pool[$urandom_range(7)] | ($urandom & 32'hF); end
      if (!d_act) begin d_act = 1'b1; d_w = 1'b0; d_a = pool[$urandom_range(7)] | ($urandom & 32'hF); end
      step(1'b0);
    end
    wait_idle_req();
    drain();

    // Reset while servicing one request with three more queued.
    for (int k = 0; k < 4; k++) begin
      i_act = 1'b1; i_a = pool[k];
      wait_idle_req();
    end
    step(1'b0);
    step(1'b1);
    step(1'b1);
    repeat (12) step(1'b0);
    i_act = 1'b1; i_a = 32'h0000_1048;
    wait_idle_req();
    drain();
    check_eq("post_reset_latency", last_i_cyc - last_acc, LAT + 2);

    // Write immediately followed by read of the same line while the queue is busy.
    d_act = 1'b1; d_w = 1'b1; d_a = pool[2]; d_l = rand_line();
    i_act = 1'b1; i_a = pool[5];
    wait_idle_req();
    d_act = 1'b1; d_w = 1'b0; d_a = pool[2] | 32'h8;
    wait_idle_req();
    drain();

    for (int c = 0; c < 400; c++) begin
      if (!i_act && $urandom_range(2) == 0) begin
        i_act = 1'b1;
        i_a   = pool[$urandom_range(7)] | ($urandom & 32'hF);
      end
      if (!d_act && $urandom_range(2) == 0) begin
        d_act = 1'b1;
        d_w   = $urandom_range(1) == 1;
        d_a   = pool[$urandom_range(7)] | ($urandom & 32'hF);
        d_l   = rand_line();
      end
      step(1'b0);
    end
    wait_idle_req();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
